// File: rtl/gpio_pkg.sv
// Shared arbiter types and sizing defaults for the GPIO register-port arbiter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package gpio_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection; ptr names the favoured requester on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Combinational one-hot winner from the current request vector
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/gpio_arbiter.sv
// Arbitrates two requesters onto a single GPIO register port with a fixed
// IDLE -> GRANT -> RESP sequence; all outputs are registered.
module gpio_arbiter
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                                 PCLK,
  input  logic                                 PRESET,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0] strb,
  output logic [NUM_REQ-1:0]                   ack,
  output logic [DATA_WIDTH-1:0]                rdata,
  output logic                                 err,
  output logic                                 gpio_wr_en,
  output logic                                 gpio_rd_en,
  output logic [ADDR_WIDTH-1:0]                gpio_reg_addr,
  output logic [DATA_WIDTH-1:0]                gpio_wdata,
  output logic [DATA_WIDTH/8-1:0]              gpio_strb,
  input  logic [DATA_WIDTH-1:0]                gpio_rdata,
  input  logic                                 gpio_error,
  output logic                                 grant_id
);

  arb_state_t state, state_nxt;
  logic       ptr;
  logic [1:0] grant;
  logic       win;

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .ptr   (ptr),
    .grant (grant)
  );

  assign win = grant[1];

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = GRANT;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The gpio_* registers double as the latched transaction, so they are only
  // non-zero for the single GRANT cycle; ack/rdata/err likewise for RESP.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ptr           <= 1'b0;
      grant_id      <= 1'b0;
      gpio_wr_en    <= 1'b0;
      gpio_rd_en    <= 1'b0;
      gpio_reg_addr <= '0;
      gpio_wdata    <= '0;
      gpio_strb     <= '0;
      ack           <= 2'b00;
      rdata         <= '0;
      err           <= 1'b0;
    end else begin
      gpio_wr_en    <= 1'b0;
      gpio_rd_en    <= 1'b0;
      gpio_reg_addr <= '0;
      gpio_wdata    <= '0;
      gpio_strb     <= '0;
      ack           <= 2'b00;
      rdata         <= '0;
      err           <= 1'b0;
      if (state == IDLE && req != 2'b00) begin
        ptr           <= ~win;
        grant_id      <= win;
        gpio_wr_en    <= we[win];
        gpio_rd_en    <= ~we[win];
        gpio_reg_addr <= addr[win];
        gpio_wdata    <= wdata[win];
        gpio_strb     <= we[win] ? strb[win] : '0;
      end
      if (state == GRANT) begin
        ack   <= grant_id ? 2'b10 : 2'b01;
        rdata <= gpio_wr_en ? '0 : gpio_rdata;
        err   <= gpio_error;
      end
    end
  end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Scoreboard bench for gpio_arbiter: a transaction-level model predicts strobes
// and acks into queues; a monitor pops and compares whenever the DUT shows them.
module tb_gpio_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = DW / 8;
  localparam logic [AW-1:0] DIR_ADDR = 8'h01;
  localparam logic [AW-1:0] BAD_ADDR = 8'h3F;

  logic                  PCLK = 1'b0;
  logic                  PRESET = 1'b1;
  logic [1:0]            req = 2'b00;
  logic [1:0]            we = 2'b00;
  logic [1:0][AW-1:0]    addr = '0;
  logic [1:0][DW-1:0]    wdata = '0;
  logic [1:0][SW-1:0]    strb = '0;
  logic [1:0]            ack;
  logic [DW-1:0]         rdata;
  logic                  err;
  logic                  gpio_wr_en, gpio_rd_en;
  logic [AW-1:0]         gpio_reg_addr;
  logic [DW-1:0]         gpio_wdata;
  logic [SW-1:0]         gpio_strb;
  logic [DW-1:0]         gpio_rdata;
  logic                  gpio_error;
  logic                  grant_id;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  gpio_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .strb(strb), .ack(ack), .rdata(rdata), .err(err),
    .gpio_wr_en(gpio_wr_en), .gpio_rd_en(gpio_rd_en),
    .gpio_reg_addr(gpio_reg_addr), .gpio_wdata(gpio_wdata),
    .gpio_strb(gpio_strb), .gpio_rdata(gpio_rdata),
    .gpio_error(gpio_error), .grant_id(grant_id)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < SW; b++) begin
      if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Simple GPIO register block: 8 registers at addresses 0..7, anything else errors
  logic [DW-1:0] slave_mem [8];
  always_comb begin
    gpio_rdata = '0;
    gpio_error = 1'b0;
    if (gpio_reg_addr < 8'd8) gpio_rdata = slave_mem[gpio_reg_addr[2:0]];
    else gpio_error = 1'b1;
  end

  always @(posedge PCLK) begin
    if (gpio_wr_en && gpio_reg_addr < 8'd8)
      slave_mem[gpio_reg_addr[2:0]] <= merge(slave_mem[gpio_reg_addr[2:0]], gpio_wdata, gpio_strb);
  end

  // Reference model at transaction level
  typedef struct { int c; int id; logic w; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s; } strobe_t;
  typedef struct { int c; int id; logic [DW-1:0] d; logic e; } resp_t;
  strobe_t sq[$];
  resp_t   aq[$];
  logic [DW-1:0] model_mem [8];
  int m_ptr = 0;
  int free_at = 0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      slave_mem[i] = '0;
      model_mem[i] = '0;
    end
    forever begin
      @(posedge PCLK);
      if (PRESET) begin
        sq.delete();
        aq.delete();
        m_ptr = 0;
        free_at = cyc + 1;
      end else if (cyc >= free_at && req != 2'b00) begin
        int w;
        strobe_t s;
        resp_t r;
        logic mapped;
        w = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
        m_ptr = 1 - w;
        mapped = addr[w] < 8'd8;
        s.c = cyc + 1; s.id = w; s.w = we[w]; s.a = addr[w]; s.d = wdata[w];
        s.s = we[w] ? strb[w] : '0;
        r.c = cyc + 2; r.id = w; r.e = !mapped; r.d = '0;
        if (we[w]) begin
          if (mapped) model_mem[addr[w][2:0]] = merge(model_mem[addr[w][2:0]], wdata[w], strb[w]);
        end else if (mapped) begin
          r.d = model_mem[addr[w][2:0]];
        end
        sq.push_back(s);
        aq.push_back(r);
        free_at = cyc + 3;
      end
      cyc = cyc + 1;
    end
  end

  // Monitor: compare every strobe and ack the DUT presents against the queues
  initial forever begin
    @(negedge PCLK);
    chk("wr_rd_exclusive", {63'd0, gpio_wr_en & gpio_rd_en}, 64'd0);
    while (sq.size() > 0 && sq[0].c < cyc) begin
      flag("strobe_missing");
      void'(sq.pop_front());
    end
    while (aq.size() > 0 && aq[0].c < cyc) begin
      flag("ack_missing");
      void'(aq.pop_front());
    end
    if (gpio_wr_en || gpio_rd_en) begin
      if (sq.size() == 0) flag("strobe_unexpected");
      else begin
        strobe_t s;
        s = sq.pop_front();
        chk("strobe_cycle", cyc, s.c);
        chk("strobe_wr_en", gpio_wr_en, s.w);
        chk("strobe_rd_en", gpio_rd_en, !s.w);
        chk("strobe_addr", gpio_reg_addr, s.a);
        chk("strobe_wdata", gpio_wdata, s.d);
        chk("strobe_strb", gpio_strb, s.s);
        chk("strobe_grant_id", grant_id, s.id);
      end
    end
    if (ack != 2'b00) begin
      if (aq.size() == 0) flag("ack_unexpected");
      else begin
        resp_t r;
        r = aq.pop_front();
        chk("ack_cycle", cyc, r.c);
        chk("ack_vector", ack, (r.id == 1) ? 2'b10 : 2'b01);
        chk("ack_rdata", rdata, r.d);
        chk("ack_err", err, r.e);
      end
    end else begin
      chk("idle_rdata", rdata, 0);
      chk("idle_err", err, 0);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_gpio_en"}, {gpio_wr_en, gpio_rd_en}, 0);
    chk({tag, "_gpio_fields"}, {gpio_reg_addr, gpio_strb}, 0);
    chk({tag, "_gpio_wdata"}, gpio_wdata, 0);
  endtask

  task automatic wait_ack(input int i);
    int n;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!ack[i] && n < 12);
    if (!ack[i]) flag($sformatf("ack%0d_timeout", i));
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    req[i] = r; we[i] = w; addr[i] = a; wdata[i] = d; strb[i] = s;
  endtask

  initial begin
    int first_id, prev_id, prev_cyc, t0;
    logic [DW-1:0] v;
    repeat (3) @(negedge PCLK);
    check_zero("reset");
    PRESET = 1'b0;

    // Write then read back the direction register
    set_req(0, 1'b1, 1'b1, DIR_ADDR, 32'h0000_00FF, 4'hF);
    wait_ack(0);
    chk("dir_write_err", err, 0);
    set_req(0, 1'b1, 1'b0, DIR_ADDR, 32'hDEAD_BEEF, 4'h0);
    wait_ack(0);
    chk("dir_readback", rdata, 32'h0000_00FF);
    req[0] = 1'b0;

    // Unmapped read
    set_req(1, 1'b1, 1'b0, BAD_ADDR, 32'h0, 4'h0);
    wait_ack(1);
    chk("unmapped_err", err, 1);
    req[1] = 1'b0;

    // Tie straight after reset: requester 0 first, then 1
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h02, 32'h1, 4'h0);
    set_req(1, 1'b1, 1'b1, 8'h03, 32'hA5A5_0000, 4'hC);
    t0 = cyc;
    wait_ack(0);
    chk("tie_first_latency", cyc - t0, 2);
    chk("tie_first_grant_id", grant_id, 0);
    req[0] = 1'b0;
    wait_ack(1);
    chk("tie_second_latency", cyc - t0, 5);
    chk("tie_second_grant_id", grant_id, 1);

    // Continuous contention: acks alternate at 3-cycle spacing
    req = 2'b11;
    prev_id = -1; prev_cyc = 0; first_id = 0;
    for (int k = 0; k < 8; k++) begin
      int n;
      n = 0;
      do begin
        @(negedge PCLK);
        n++;
      end while (ack == 2'b00 && n < 8);
      if (ack == 2'b00) flag("contention_timeout");
      else begin
        int id;
        id = ack[1] ? 1 : 0;
        if (prev_id >= 0) begin
          chk("contention_alternate", id, 1 - prev_id);
          chk("contention_spacing", cyc - prev_cyc, 3);
        end else first_id = id;
        prev_id = id;
        prev_cyc = cyc;
        set_req(id, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom, 4'($urandom));
      end
    end
    chk("contention_first", first_id, 1'b0);
    req = 2'b00;
    repeat (3) @(negedge PCLK);

    // Reset during GRANT aborts the ack but keeps the sampled write
    v = $urandom;
    set_req(0, 1'b1, 1'b1, 8'h05, v, 4'hF);
    begin
      int n;
      n = 0;
      do begin
        @(negedge PCLK);
        n++;
      end while (!gpio_wr_en && n < 6);
      if (!gpio_wr_en) flag("grant_wait_timeout");
    end
    PRESET = 1'b1;
    req[0] = 1'b0;
    @(negedge PCLK);
    check_zero("abort");
    PRESET = 1'b0;
    set_req(1, 1'b1, 1'b0, 8'h05, 32'h0, 4'h0);
    t0 = cyc;
    wait_ack(1);
    chk("fresh_latency", cyc - t0, 2);
    chk("fresh_readback", rdata, v);
    req[1] = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      @(negedge PCLK);
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), $urandom, 4'($urandom));
          else req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 9) < 3)
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), $urandom, 4'($urandom));
        end else begin
          if ($urandom_range(0, 99) < 3) req[i] = 1'b0;
          else if ($urandom_range(0, 9) < 2) begin
            wdata[i] = $urandom;
            addr[i] = 8'($urandom_range(0, 9));
          end
        end
      end
    end
    req = 2'b00;
    repeat (6) @(negedge PCLK);
    chk("drain_strobe_queue", sq.size(), 0);
    chk("drain_ack_queue", aq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
